i2c_reg_seq: RTL and testbench

Register-access sequencer that sits directly upstream of the byte-level I2C master (cmd/din/wr_i2c command interface). It accepts one register read or write request from a host, then issues the full I2C command sequence to the master: START, address, register pointer, data or RESTART+read, and STOP. It returns one response carrying the read data and an error flag when the slave NACKs.

---
 rtl/i2c_reg_seq_if.sv | 37 +++
 rtl/i2c_reg_seq.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_i2c_reg_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_seq_if.sv
// i2c_reg_seq_if: host request/response and byte-level I2C master command
// signals for the register-access sequencer.
// slave  : the sequencer's view (takes host requests, drives the master).
// master : the environment's view (host plus byte-level I2C master).
interface i2c_reg_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic [2:0] m_cmd;
  logic [7:0] m_din;
  logic       m_wr;
  logic       m_ready;
  logic       m_done_tick;
  logic       m_ack;
  logic [7:0] m_dout;

  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  m_ready, m_done_tick, m_ack, m_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output m_cmd, m_din, m_wr
  );

  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    output m_ready, m_done_tick, m_ack, m_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  m_cmd, m_din, m_wr
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: accepts one register read/write request and walks the byte-level
// I2C master through START, address, pointer, data or RESTART+read, and STOP,
// then returns a single response (read data, NACK error flag).
// Optional feature: define I2C_SEQ_RETRY_EN to retry a NACKed device-address
// byte of the initial START up to MAX_RETRY more times (EEPROM write polling).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | req_ready high, waiting for a host request
// START    | START condition
// DEVW     | device address with write bit
// REG      | register pointer byte
// WDATA    | write data byte (write requests only)
// RESTART  | repeated START (read requests only)
// DEVR     | device address with read bit
// READ     | read one byte, master sends NACK
// STOP     | STOP condition (normal end, error end, or retry)
// RESP     | one-cycle rsp_valid pulse
//
// Every step state has an issue phase (wait_q = 0: m_wr pending on m_ready) and
// a wait phase (wait_q = 1: wait for m_ready again, ignoring the cycle m_wr is
// high because the master's ready flag is still stale then).
module i2c_reg_seq #(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  i2c_reg_seq_if.slave bus
);

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WRITE   = 3'b001;
  localparam logic [2:0] CMD_READ    = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEVW,
    S_REG,
    S_WDATA,
    S_RESTART,
    S_DEVR,
    S_READ,
    S_STOP,
    S_RESP
  } state_t;

  state_t     state_q;
  logic       wait_q;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic       ack_q;
  logic       err_q;
  logic [7:0] rd_byte_q;

  logic       req_ready_q;
  logic       busy_q;
  logic       rsp_valid_q;
  logic       rsp_err_q;
  logic [7:0] rsp_rdata_q;
  logic [2:0] m_cmd_q;
  logic [7:0] m_din_q;
  logic       m_wr_q;

  state_t     next_step_d;
  logic [2:0] next_cmd_d;
  logic [7:0] next_din_d;
  logic       err_set_d;
  logic       is_wr_byte;
  logic       nack_d;
  logic       step_done;
  logic       accept;
  logic       retry_now_d;
  logic       restart_d;

  assign accept    = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
  assign step_done = wait_q && !m_wr_q && bus.m_ready;

  // A done tick in the completing cycle wins over the stored ack bit.
  always_comb begin
    is_wr_byte = (state_q == S_DEVW) || (state_q == S_REG) ||
                 (state_q == S_WDATA) || (state_q == S_DEVR);
    nack_d     = is_wr_byte && (bus.m_done_tick ? bus.m_ack : ack_q);
  end

`ifdef I2C_SEQ_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  logic [RETRY_W-1:0] retry_q;
  logic               retry_pend_q;

  // Retry decision: only the DEVW byte after a fresh START may be retried.
  always_comb begin
    retry_now_d = (state_q == S_DEVW) && nack_d &&
                  (retry_q < RETRY_W'(MAX_RETRY));
    restart_d   = (state_q == S_STOP) && retry_pend_q;
  end

  // Retry counter clears per request; pending flag turns the next STOP into a restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
    end else if (accept) begin
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
    end else if (step_done && retry_now_d) begin
      retry_pend_q <= 1'b1;
    end else if (step_done && restart_d) begin
      retry_pend_q <= 1'b0;
      retry_q      <= retry_q + RETRY_W'(1);
    end
  end
`else
  // Without retry every NACK takes the error path.
  always_comb begin
    retry_now_d = 1'b0;
    restart_d   = 1'b0;
  end

  // MAX_RETRY has no hardware in this build; kept for a uniform instantiation.
  if (MAX_RETRY > 0) begin : g_retry_off
  end
`endif

  // Step ordering and the command/data each step presents to the master.
  always_comb begin
    next_step_d = S_IDLE;
    err_set_d   = 1'b0;
    case (state_q)
      S_START:   next_step_d = S_DEVW;
      S_DEVW: begin
        if (nack_d) begin
          next_step_d = S_STOP;
          err_set_d   = !retry_now_d;
        end else begin
          next_step_d = S_REG;
        end
      end
      S_REG: begin
        if (nack_d) begin
          next_step_d = S_STOP;
          err_set_d   = 1'b1;
        end else begin
          next_step_d = rw_q ? S_RESTART : S_WDATA;
        end
      end
      S_WDATA: begin
        next_step_d = S_STOP;
        err_set_d   = nack_d;
      end
      S_RESTART: next_step_d = S_DEVR;
      S_DEVR: begin
        if (nack_d) begin
          next_step_d = S_STOP;
          err_set_d   = 1'b1;
        end else begin
          next_step_d = S_READ;
        end
      end
      S_READ:    next_step_d = S_STOP;
      S_STOP:    next_step_d = restart_d ? S_START : S_RESP;
      default:   next_step_d = S_IDLE;
    endcase

    next_cmd_d = CMD_START;
    next_din_d = 8'h00;
    case (next_step_d)
      S_DEVW: begin
        next_cmd_d = CMD_WRITE;
        next_din_d = {dev_q, 1'b0};
      end
      S_REG: begin
        next_cmd_d = CMD_WRITE;
        next_din_d = reg_q;
      end
      S_WDATA: begin
        next_cmd_d = CMD_WRITE;
        next_din_d = wdata_q;
      end
      S_RESTART: next_cmd_d = CMD_RESTART;
      S_DEVR: begin
        next_cmd_d = CMD_WRITE;
        next_din_d = {dev_q, 1'b1};
      end
      S_READ: begin
        next_cmd_d = CMD_READ;
        next_din_d = 8'h01;
      end
      S_STOP:    next_cmd_d = CMD_STOP;
      default: begin
        next_cmd_d = CMD_START;
        next_din_d = 8'h00;
      end
    endcase
  end

  // Main sequencer: request capture, issue/wait handshake, byte capture, response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rd_byte_q   <= 8'h00;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
      m_cmd_q     <= CMD_START;
      m_din_q     <= 8'h00;
      m_wr_q      <= 1'b0;
    end else begin
      m_wr_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rw_q        <= bus.req_rw;
            dev_q       <= bus.req_dev;
            reg_q       <= bus.req_reg;
            wdata_q     <= bus.req_wdata;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_byte_q   <= 8'h00;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_START;
            m_cmd_q     <= CMD_START;
            m_din_q     <= 8'h00;
            m_wr_q      <= bus.m_ready;
            wait_q      <= bus.m_ready;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          if (bus.m_done_tick && is_wr_byte) begin
            ack_q <= bus.m_ack;
          end
          if (bus.m_done_tick && (state_q == S_READ)) begin
            rd_byte_q <= bus.m_dout;
          end
          if (!wait_q) begin
            m_wr_q <= bus.m_ready;
            wait_q <= bus.m_ready;
          end else if (step_done) begin
            ack_q <= 1'b0;
            if (err_set_d) begin
              err_q <= 1'b1;
            end
            if (next_step_d == S_RESP) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err_q;
              rsp_rdata_q <= (rw_q && !err_q) ? rd_byte_q : 8'h00;
              m_cmd_q     <= CMD_START;
              m_din_q     <= 8'h00;
              wait_q      <= 1'b0;
            end else begin
              state_q <= next_step_d;
              m_cmd_q <= next_cmd_d;
              m_din_q <= next_din_d;
              m_wr_q  <= bus.m_ready;
              wait_q  <= bus.m_ready;
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.m_cmd     = m_cmd_q;
  assign bus.m_din     = m_din_q;
  assign bus.m_wr      = m_wr_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: randomized bench for i2c_reg_seq with a behavioural I2C
// master/slave model and a scoreboard of expected commands and responses.
// Honours I2C_SEQ_RETRY_EN (uses MAX_RETRY = 2 when defined).
module tb_i2c_reg_seq;

`ifdef I2C_SEQ_RETRY_EN
  localparam int TB_MAX_RETRY = 2;
  localparam bit RETRY_EN     = 1'b1;
`else
  localparam int TB_MAX_RETRY = 3;
  localparam bit RETRY_EN     = 1'b0;
`endif

  localparam logic [2:0] C_START = 3'b000, C_WR = 3'b001, C_RD = 3'b010,
                         C_STOP = 3'b011, C_RESTART = 3'b100;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  i2c_reg_seq_if bus();

  i2c_reg_seq #(.MAX_RETRY(TB_MAX_RETRY)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int n_cmd_seen = 0;
  int n_rsp_seen = 0;

  logic [10:0] exp_cmd_q[$];
  logic [8:0]  exp_rsp_q[$];

  // slave behaviour for the current request
  int         plan_devw_nacks = 0;
  int         plan_stage = 0;      // 0 none, 2 reg, 3 wdata, 4 devr
  logic [7:0] plan_rdata = 8'h00;
  int         devw_cnt = 0;
  bit         hold_off = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected command stream from the access rules (limit < 0: whole request + response).
  task automatic build_exp(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rd,
                           input int devw_nacks, input int stage, input int limit);
    logic [10:0] cl[$];
    bit err = 1'b0;
    bit addr_ok = 1'b0;
    int attempts = RETRY_EN ? TB_MAX_RETRY + 1 : 1;
    for (int a = 0; a < attempts; a++) begin
      cl.push_back({C_START, 8'h00});
      cl.push_back({C_WR, dev, 1'b0});
      if (a >= devw_nacks) begin
        addr_ok = 1'b1;
        break;
      end
      cl.push_back({C_STOP, 8'h00});
    end
    if (!addr_ok) err = 1'b1;
    else begin
      cl.push_back({C_WR, rg});
      if (stage == 2) begin
        err = 1'b1;
        cl.push_back({C_STOP, 8'h00});
      end else if (!rw) begin
        cl.push_back({C_WR, wd});
        if (stage == 3) err = 1'b1;
        cl.push_back({C_STOP, 8'h00});
      end else begin
        cl.push_back({C_RESTART, 8'h00});
        cl.push_back({C_WR, dev, 1'b1});
        if (stage == 4) begin
          err = 1'b1;
          cl.push_back({C_STOP, 8'h00});
        end else begin
          cl.push_back({C_RD, 8'h01});
          cl.push_back({C_STOP, 8'h00});
        end
      end
    end
    for (int i = 0; i < cl.size(); i++) begin
      if (limit < 0 || i < limit) exp_cmd_q.push_back(cl[i]);
    end
    if (limit < 0) exp_rsp_q.push_back({err, (err || !rw) ? 8'h00 : rd});
  endtask

  // Monitor / scoreboard: compares every master command and every response.
  initial begin
    logic [10:0] e;
    logic [8:0]  r;
    bit prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_wr = 1'b0;
      end else begin
        chk("busy_vs_ready", bus.busy, {31'd0, ~bus.req_ready});
        if (bus.m_wr) begin
          n_cmd_seen++;
          chk("m_wr_when_ready", bus.m_ready, 1);
          chk("m_wr_gap", prev_wr, 0);
          if (exp_cmd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_unexpected: got cmd %0h din %0h, none expected", bus.m_cmd, bus.m_din);
          end else begin
            e = exp_cmd_q.pop_front();
            chk("m_cmd", bus.m_cmd, e[10:8]);
            chk("m_din", bus.m_din, e[7:0]);
          end
        end
        if (bus.rsp_valid) begin
          n_rsp_seen++;
          if (exp_rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got err %0b rdata %0h, none expected", bus.rsp_err, bus.rsp_rdata);
          end else begin
            r = exp_rsp_q.pop_front();
            chk("rsp_err", bus.rsp_err, r[8]);
            chk("rsp_rdata", bus.rsp_rdata, r[7:0]);
          end
        end
        prev_wr = bus.m_wr;
      end
    end
  end

  // Byte-level I2C master plus addressed slave, reacting one cycle after m_wr.
  initial begin
    int cnt = 0;
    logic [2:0] pc = C_START;
    bit done_given = 1'b0;
    bit after_rs = 1'b0;
    int bidx = 0;
    bit saw;
    logic [2:0] c;
    bit n;
    bus.m_ready = 1'b1;
    bus.m_done_tick = 1'b0;
    bus.m_ack = 1'b0;
    bus.m_dout = 8'h00;
    forever begin
      @(negedge clk);
      saw = bus.m_wr;
      c = bus.m_cmd;
      @(posedge clk);
      #1;
      bus.m_done_tick = 1'b0;
      bus.m_ack = 1'($urandom_range(0, 1));
      bus.m_dout = 8'($urandom);
      if (!reset_n) begin
        cnt = 0;
        bus.m_ready = !hold_off;
        continue;
      end
      if (saw) begin
        pc = c;
        cnt = $urandom_range(1, 4);
        done_given = 1'b0;
        if (c == C_START) begin
          after_rs = 1'b0;
          bidx = 0;
        end
        if (c == C_RESTART) begin
          after_rs = 1'b1;
          bidx = 0;
        end
      end else if (cnt > 0) begin
        cnt--;
        if ((pc == C_WR || pc == C_RD) &&
            ((cnt == 1 && $urandom_range(0, 2) == 0) || (cnt == 0 && !done_given))) begin
          done_given = 1'b1;
          bus.m_done_tick = 1'b1;
          if (pc == C_RD) bus.m_dout = plan_rdata;
          else begin
            if (!after_rs) begin
              case (bidx)
                0: begin
                  n = (devw_cnt < plan_devw_nacks);
                  devw_cnt++;
                end
                1: n = (plan_stage == 2);
                2: n = (plan_stage == 3);
                default: n = 1'b0;
              endcase
            end else begin
              n = (bidx == 0) && (plan_stage == 4);
            end
            bidx++;
            bus.m_ack = n;
          end
        end
      end
      bus.m_ready = (cnt == 0) && !hold_off;
    end
  end

  task automatic wait_ready();
    int c = 0;
    while (!bus.req_ready && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
  endtask

  task automatic drive_req(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd);
    bus.req_valid = 1'b1;
    bus.req_rw = rw;
    bus.req_dev = dev;
    bus.req_reg = rg;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_req(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input int devw_nacks, input int stage, input bit hold);
    int target;
    int cyc = 0;
    wait_ready();
    plan_devw_nacks = devw_nacks;
    plan_stage = stage;
    plan_rdata = rd;
    devw_cnt = 0;
    build_exp(rw, dev, rg, wd, rd, devw_nacks, stage, -1);
    target = n_rsp_seen + 1;
    if (hold) begin
      hold_off = 1'b1;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    end
    drive_req(rw, dev, rg, wd);
    while (n_rsp_seen < target && cyc < 3000) begin
      if (cyc == 3) hold_off = 1'b0;
      // host noise while busy must not start another transaction
      bus.req_valid = ($urandom_range(0, 5) == 0);
      bus.req_rw = 1'($urandom_range(0, 1));
      bus.req_dev = 7'($urandom);
      bus.req_reg = 8'($urandom);
      bus.req_wdata = 8'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.req_valid = 1'b0;
    hold_off = 1'b0;
    chk("rsp_arrived", {31'd0, n_rsp_seen >= target}, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_m_wr"}, bus.m_wr, 0);
    chk({tag, "_m_cmd"}, bus.m_cmd, 0);
    chk({tag, "_m_din"}, bus.m_din, 0);
  endtask

  task automatic reset_mid_test();
    int base;
    int rsp_before;
    int cyc = 0;
    wait_ready();
    plan_devw_nacks = 0;
    plan_stage = 0;
    devw_cnt = 0;
    build_exp(1'b0, 7'h50, 8'h10, 8'h77, 8'h00, 0, 0, 3);
    base = n_cmd_seen;
    drive_req(1'b0, 7'h50, 8'h10, 8'h77);
    while (n_cmd_seen < base + 3 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reg_cmd_reached", {31'd0, n_cmd_seen >= base + 3}, 1);
    reset_n = 1'b0;
    rsp_before = n_rsp_seen;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midrst2");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_ready", bus.req_ready, 1);
    chk("no_rsp_after_rst", n_rsp_seen, rsp_before);
    chk("cmd_q_after_rst", exp_cmd_q.size(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stage_tab[6];
    stage_tab[0] = 0; stage_tab[1] = 0; stage_tab[2] = 0;
    stage_tab[3] = 2; stage_tab[4] = 3; stage_tab[5] = 4;
    bus.req_valid = 1'b0;
    bus.req_rw = 1'b0;
    bus.req_dev = 7'h00;
    bus.req_reg = 8'h00;
    bus.req_wdata = 8'h00;
    #2;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_req(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 0, 1'b0);  // plain write
    run_req(1'b1, 7'h50, 8'h20, 8'h00, 8'h3C, 0, 0, 1'b0);  // plain read
    run_req(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 0, 1'b0);  // one address NACK
    run_req(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 2, 0, 1'b0);  // two address NACKs
    run_req(1'b1, 7'h50, 8'h20, 8'h00, 8'h5A, 99, 0, 1'b0); // always NACK
    run_req(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 2, 1'b0);  // reg NACK
    run_req(1'b0, 7'h51, 8'h11, 8'h42, 8'h00, 0, 3, 1'b0);  // wdata NACK
    run_req(1'b1, 7'h52, 8'h33, 8'h00, 8'hC3, 0, 4, 1'b0);  // read-address NACK
    run_req(1'b1, 7'h7F, 8'hFF, 8'h00, 8'hFF, 0, 0, 1'b1);  // master busy at accept
    reset_mid_test();
    run_req(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 0, 1'b0);  // normal after reset

    for (int i = 0; i < 40; i++) begin
      run_req(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
              stage_tab[$urandom_range(0, 5)],
              ($urandom_range(0, 3) == 0));
    end

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("cmd_q_empty", exp_cmd_q.size(), 0);
    chk("rsp_q_empty", exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
